// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared seven-segment definitions: segment bit positions, glyph table and
// the nibble-to-glyph helper used by every display block.
package sevenseg_scan_driver_pkg;

  // Bit position of each segment in a 7-bit glyph (gfedcba order).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All segments dark, active-high encoding (before any pin inversion).
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Hex glyphs, active-high gfedcba.
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // Map a nibble onto its hex glyph.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Display-side bundle of the scan driver: control/data from the datapath
// and the registered pins toward the board.
interface sevenseg_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  logic                    enable;
  logic                    lz_en;
  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     dp_in;
  logic [6:0]              seg;
  logic                    dp;
  logic [N_DIGITS-1:0]     an;
  logic                    frame_start;
  logic                    pending;

  // Datapath side: supplies digits, observes the display pins.
  modport master (
    output enable, lz_en, load, value, dp_in,
    input  seg, dp, an, frame_start, pending
  );

  // Driver side.
  modport slave (
    input  enable, lz_en, load, value, dp_in,
    output seg, dp, an, frame_start, pending
  );
endinterface

// File: rtl/sevenseg_scan_driver_hex_to_seg7.sv
// Combinational nibble-to-glyph decoder with a blanking override.
module hex_to_seg7
  import sevenseg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blank wins over the decoded glyph.
  always_comb begin
    seg_o = blank_i ? SEG_OFF : hex_glyph(nibble_i);
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with leading-zero suppression
// and a double-buffered digit store swapped only at frame boundaries.
module sevenseg_scan_driver
  import sevenseg_scan_driver_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sevenseg_scan_driver_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VW = 4 * N_DIGITS;

  localparam logic [PW-1:0]       PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_POL  = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic                DP_POL   = (SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_POL   = {N_DIGITS{AN_ACTIVE_LOW != 0}};

  logic [PW-1:0]       prescaler_q, prescaler_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [VW-1:0]       act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                pending_q, pending_d;
  logic                first_q, first_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                fs_q, fs_d;

  logic                tick, boundary;
  logic [3:0]          cur_nibble;
  logic                cur_blank;
  logic [6:0]          glyph;
  logic [N_DIGITS-1:0] onehot;

  assign tick     = bus.enable && (prescaler_q == PRE_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  // Scan position: prescaler and digit index advance only while enabled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    prescaler_d = prescaler_q;
    idx_d       = idx_q;
    if (bus.enable) begin
      if (tick) begin
        prescaler_d = '0;
        idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        prescaler_d = prescaler_q + 1'b1;
      end
    end
    // Remember that the current position is the first of a new frame; held
    // while disabled so the pulse lines up with the first visible digit 0.
    first_d = bus.enable ? boundary : first_q;
  end

  // Double buffer: loads land in pending, swapped into active at the boundary.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    pending_d  = pending_q;
    if (bus.load) begin
      pend_val_d = bus.value;
      pend_dp_d  = bus.dp_in;
      pending_d  = 1'b1;
    end
    if (boundary) begin
      if (bus.load) begin
        act_val_d = bus.value;
        act_dp_d  = bus.dp_in;
      end else if (pending_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
      pending_d = 1'b0;
    end
  end

  // Current digit nibble, leading-zero blanking and digit select.
  always_comb begin
    cur_nibble = act_val_q[4*int'(idx_q) +: 4];
    cur_blank  = 1'b0;
    if (bus.lz_en && (idx_q != '0)) begin
      cur_blank = 1'b1;
      for (int j = 0; j < N_DIGITS; j++) begin
        if (j >= int'(idx_q) && act_val_q[4*j +: 4] != 4'h0) cur_blank = 1'b0;
      end
    end
    for (int i = 0; i < N_DIGITS; i++) onehot[i] = (int'(idx_q) == i);
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (cur_nibble),
    .blank_i  (cur_blank),
    .seg_o    (glyph)
  );

  // Pin values for the next cycle, dark whenever scanning is disabled.
  always_comb begin
    seg_d = SEG_OFF ^ SEG_POL;
    dp_d  = DP_POL;
    an_d  = AN_POL;
    fs_d  = 1'b0;
    if (bus.enable) begin
      seg_d = glyph ^ SEG_POL;
      dp_d  = act_dp_q[idx_q] ^ DP_POL;
      an_d  = onehot ^ AN_POL;
      fs_d  = first_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      // NOTE: both digit buffers are reset so the display starts from known zeros.
      act_val_q   <= '0;
      act_dp_q    <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pending_q   <= 1'b0;
      first_q     <= 1'b0;
      seg_q       <= SEG_OFF ^ SEG_POL;
      dp_q        <= DP_POL;
      an_q        <= AN_POL;
      fs_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pending_q   <= pending_d;
      first_q     <= first_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      fs_q        <= fs_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench: a frame-position reference model predicts each cycle's
// pins; a negedge monitor pops and compares them against the DUT.
module tb_sevenseg_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FRAME = N * DIV;

  logic clk;
  logic rst_n;

  sevenseg_scan_driver_if #(.N_DIGITS(N)) bus ();

  sevenseg_scan_driver #(
    .N_DIGITS       (N),
    .REFRESH_DIV    (DIV),
    .SEG_ACTIVE_LOW (0),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];

  logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position within the frame counted in enabled cycles.
  int          m_pos;
  int          m_frames;
  logic [15:0] m_act_val, m_pend_val;
  logic [3:0]  m_act_dp,  m_pend_dp;
  logic        m_pending;

  // Current input settings used by the stimulus helpers.
  logic        cur_en, cur_lz;
  logic [15:0] cur_val;
  logic [3:0]  cur_dp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and push the pins expected after the next edge.
  task automatic cycle(input logic rst, input logic en, input logic lz, input logic ld,
                       input logic [15:0] val, input logic [3:0] dpi);
    exp_t e;
    int   d;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic        blank, bnd;
    @(negedge clk);
    #1;
    rst_n      = rst;
    bus.enable = en;
    bus.lz_en  = lz;
    bus.load   = ld;
    bus.value  = val;
    bus.dp_in  = dpi;
    if (!rst) begin
      m_pos = 0; m_frames = 0; m_pending = 1'b0;
      m_act_val = '0; m_pend_val = '0; m_act_dp = '0; m_pend_dp = '0;
      e = '{an: 4'hF, seg: 7'h00, dp: 1'b0, fs: 1'b0, pend: 1'b0};
    end else begin
      if (en) begin
        d     = m_pos / DIV;
        nib   = m_act_val[4*d +: 4];
        upper = m_act_val >> (4 * d);
        blank = lz && (d > 0) && (upper == 16'h0);
        e.an  = ~(4'b0001 << d);
        e.seg = blank ? 7'h00 : glyph_tbl[nib];
        e.dp  = m_act_dp[d];
        e.fs  = (m_pos == 0) && (m_frames > 0);
      end else begin
        e.an = 4'hF; e.seg = 7'h00; e.dp = 1'b0; e.fs = 1'b0;
      end
      bnd = en && (m_pos == FRAME - 1);
      if (ld) begin
        m_pend_val = val; m_pend_dp = dpi; m_pending = 1'b1;
      end
      if (bnd) begin
        if (ld) begin
          m_act_val = val; m_act_dp = dpi;
        end else if (m_pending) begin
          m_act_val = m_pend_val; m_act_dp = m_pend_dp;
        end
        m_pending = 1'b0;
      end
      if (en) begin
        m_pos++;
        if (m_pos == FRAME) begin
          m_pos = 0;
          m_frames++;
        end
      end
      e.pend = m_pending;
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, cur_en, cur_lz, 1'b0, cur_val, cur_dp);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    cur_val = v;
    cur_dp  = p;
    cycle(1'b1, cur_en, cur_lz, 1'b1, v, p);
  endtask

  // Advance (bounded) until the model reaches a given in-frame position.
  task automatic run_to(input int pos);
    for (int i = 0; i < 2 * FRAME && m_pos != pos; i++) run(1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, cur_en, cur_lz, 1'b0, cur_val, cur_dp);
  endtask

  // Monitor: every negedge the DUT presents one set of pins.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("an",          32'(bus.an),          32'(e.an));
      check("seg",         32'(bus.seg),         32'(e.seg));
      check("dp",          32'(bus.dp),          32'(e.dp));
      check("frame_start", 32'(bus.frame_start), 32'(e.fs));
      check("pending",     32'(bus.pending),     32'(e.pend));
    end
  end

  initial begin
    logic [15:0] v;
    rst_n = 1'b0;
    cur_en = 1'b1; cur_lz = 1'b0; cur_val = '0; cur_dp = '0;
    bus.enable = 1'b1; bus.lz_en = 1'b0; bus.load = 1'b0; bus.value = '0; bus.dp_in = '0;

    // Reset, then release with enable high: digit 0 shows 3F.
    do_reset(3);
    run(3);

    // Scan order with 12AF and a couple of decimal points.
    do_load(16'h12AF, 4'b0101);
    run(3 * FRAME);

    // Leading-zero suppression.
    cur_lz = 1'b1;
    do_load(16'h0040, 4'b1000);
    run(2 * FRAME + 3);
    do_load(16'h0000, 4'b0000);
    run(2 * FRAME);

    // Tear-free update mid-frame while digit 2 is on.
    do_load(16'h9876, 4'b0000);
    run(FRAME + 2);
    run_to(2 * DIV + 1);
    do_load(16'h1111, 4'b0010);
    run(FRAME + 4);

    // Load coincident with the boundary tick.
    run_to(FRAME - 1);
    do_load(16'hC0DE, 4'b0001);
    run(FRAME + 2);

    // Enable drop on digit 1 for 10 cycles.
    run_to(DIV + 1);
    cur_en = 1'b0;
    run(10);
    do_load(16'h5A5A, 4'b1111);
    cur_en = 1'b1;
    run(2 * FRAME);

    // Reset mid-digit with data pending.
    run_to(DIV + 2);
    do_load(16'hFFFF, 4'b1111);
    do_reset(2);
    run(FRAME + 2);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      cur_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) cur_lz = ~cur_lz;
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 2));
      end else if ($urandom_range(0, 14) == 0) begin
        for (int k = 0; k < N; k++) v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        do_load(v, 4'($urandom));
      end else begin
        run(1);
      end
    end

    @(negedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
